// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor.
// Holds the sweep FSM state encoding and the saturating-counter arithmetic.
package bp_pkg;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

  // Widest counter the helpers support; callers zero-extend into this width.
  localparam int unsigned BP_CNT_MAX_WIDTH = 4;

  // Next value of a width-bit saturating counter after one resolved branch.
  function automatic logic [BP_CNT_MAX_WIDTH-1:0] sat_next(
    input logic [BP_CNT_MAX_WIDTH-1:0] cnt,
    input logic                        taken,
    input int unsigned                 width
  );
    logic [BP_CNT_MAX_WIDTH-1:0] max_v;
    max_v = BP_CNT_MAX_WIDTH'((1 << width) - 1);
    if (taken) begin
      sat_next = (cnt == max_v) ? cnt : cnt + 1'b1;
    end else begin
      sat_next = (cnt == '0) ? cnt : cnt - 1'b1;
    end
  endfunction

  // Weakly not-taken: one below the midpoint of the counter range.
  function automatic logic [BP_CNT_MAX_WIDTH-1:0] cnt_init(input int unsigned width);
    cnt_init = BP_CNT_MAX_WIDTH'((1 << (width - 1)) - 1);
  endfunction

endpackage

// File: rtl/bp_ghr.sv
// Global history register for the gshare predictor.
// Shifts speculatively on each consumed prediction; a resolved mispredict
// rebuilds history from the snapshot carried down the pipe and wins over
// a same-cycle speculative shift. Held while run_i is low.
module bp_ghr #(
  parameter int unsigned GHR_WIDTH = 10
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 run_i,
  input  logic                 predict_valid_i,
  input  logic                 predict_taken_i,
  input  logic                 update_en_i,
  input  logic                 mispredict_i,
  input  logic [GHR_WIDTH-1:0] ex_ghr_i,
  input  logic                 actual_taken_i,
  output logic [GHR_WIDTH-1:0] ghr_o
);

  logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
  logic [GHR_WIDTH-1:0] spec_shift, recover_shift;

  // A one-bit history simply becomes the newest outcome.
  generate
    if (GHR_WIDTH == 1) begin : g_narrow
      assign spec_shift    = predict_taken_i;
      assign recover_shift = actual_taken_i;
    end else begin : g_wide
      assign spec_shift    = {ghr_q[GHR_WIDTH-2:0], predict_taken_i};
      assign recover_shift = {ex_ghr_i[GHR_WIDTH-2:0], actual_taken_i};
    end
  endgenerate

  // Next history: recovery first, then speculative shift, else hold.
  always_comb begin
    ghr_d = ghr_q;
    if (run_i) begin
      if (update_en_i && mispredict_i) begin
        ghr_d = recover_shift;
      end else if (predict_valid_i) begin
        ghr_d = spec_shift;
      end
    end
  end

  // History register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign ghr_o = ghr_q;

endmodule

// File: rtl/branch_predictor_gshare.sv
// gshare direction predictor: table of saturating counters indexed by
// PC[IB+1:2] XOR global history. The table has no reset; a sweep FSM writes
// the initial value into every entry after reset before ready rises.
// Optional build macro BP_PERF_CNT_EN adds saturating lookup/mispredict counters.
//
// Handshake: a prediction is consumed when predict_valid is high in a cycle
// where ready is high; update_en qualifies ex_pc/ex_ghr/actual_taken/mispredict
// for one cycle and is honoured only while ready is high.
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 1024,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned CNT_WIDTH   = 2,
  parameter int unsigned GHR_WIDTH   = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 predict_valid,
  output logic                 predict_taken,
  output logic [GHR_WIDTH-1:0] predict_ghr,
  output logic                 ready,
  input  logic                 update_en,
  input  logic [PC_WIDTH-1:0]  ex_pc,
  input  logic [GHR_WIDTH-1:0] ex_ghr,
  input  logic                 actual_taken,
  input  logic                 mispredict,
  output bp_state_e            dbg_state
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]          perf_lookups,
  output logic [31:0]          perf_mispredicts
`endif
);

  localparam int unsigned IB = $clog2(NUM_ENTRIES);
  localparam logic [CNT_WIDTH-1:0] CINIT = CNT_WIDTH'(cnt_init(CNT_WIDTH));
  localparam logic [IB-1:0] LAST_IDX = IB'(NUM_ENTRIES - 1);

  bp_state_e            state_q;
  logic [IB-1:0]        ptr_q;
  logic                 ready_q;
  logic [CNT_WIDTH-1:0] cnt_table_q [NUM_ENTRIES];

  logic [GHR_WIDTH-1:0] ghr;
  logic [IB-1:0]        idx, ex_idx;
  logic [CNT_WIDTH-1:0] upd_val;

  assign idx    = pc[IB+1:2]    ^ IB'(ghr);
  assign ex_idx = ex_pc[IB+1:2] ^ IB'(ex_ghr);
  assign upd_val = CNT_WIDTH'(sat_next(BP_CNT_MAX_WIDTH'(cnt_table_q[ex_idx]),
                                       actual_taken, CNT_WIDTH));

  // Sweep FSM: walk every entry once after reset, then stay in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BP_INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        BP_INIT: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == LAST_IDX) begin
            state_q <= BP_RUN;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= BP_RUN;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Single table write port: sweep writes in INIT, training writes in RUN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == BP_INIT) begin
        cnt_table_q[ptr_q] <= CINIT;
      end else if (update_en) begin
        cnt_table_q[ex_idx] <= upd_val;
      end
    end
  end

  bp_ghr #(
    .GHR_WIDTH (GHR_WIDTH)
  ) u_ghr (
    .clk_i           (clk),
    .reset_i         (reset),
    .run_i           (ready_q),
    .predict_valid_i (predict_valid),
    .predict_taken_i (predict_taken),
    .update_en_i     (update_en),
    .mispredict_i    (mispredict),
    .ex_ghr_i        (ex_ghr),
    .actual_taken_i  (actual_taken),
    .ghr_o           (ghr)
  );

  // Prediction reads the pre-update counter; no bypass from a same-cycle write.
  assign predict_taken = ready_q & cnt_table_q[idx][CNT_WIDTH-1];
  assign predict_ghr   = ghr;
  assign ready         = ready_q;
  assign dbg_state     = state_q;

`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_lookups_q, perf_mispredicts_q;

  // Saturating event counters, active only once the table is live.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_lookups_q     <= '0;
      perf_mispredicts_q <= '0;
    end else if (ready_q) begin
      if (predict_valid && (perf_lookups_q != 32'hFFFF_FFFF)) begin
        perf_lookups_q <= perf_lookups_q + 32'd1;
      end
      if (update_en && mispredict && (perf_mispredicts_q != 32'hFFFF_FFFF)) begin
        perf_mispredicts_q <= perf_mispredicts_q + 32'd1;
      end
    end
  end

  assign perf_lookups     = perf_lookups_q;
  assign perf_mispredicts = perf_mispredicts_q;
`endif

endmodule
